// File: rtl/gb_video_pkg.sv
// Shared Game Boy video constants and the LCD capture state encoding.
package gb_video_pkg;

  localparam int GB_H_ACTIVE = 160;
  localparam int GB_V_ACTIVE = 144;
  localparam int FB_ADDR_W   = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    ACTIVE
  } cap_state_e;

endpackage

// File: rtl/gb_sig_sync.sv
// N-stage synchroniser with a registered rising-edge pulse.
// q_o and rise_o are aligned: rise_o=1 marks the clk where q_o just went high.
module gb_sig_sync #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] s_q [N];
  logic [W-1:0] e_q;
  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) s_q[i] <= '0;
      e_q <= '0;
      r_q <= '0;
    end else begin
      s_q[0] <= d_i;
      for (int i = 1; i < N; i++) s_q[i] <= s_q[i-1];
      e_q <= s_q[N-1];
      r_q <= s_q[N-1] & ~e_q;
    end
  end

  assign q_o    = e_q;
  assign rise_o = r_q;

endmodule

// File: rtl/gb_lcd_capture.sv
// Game Boy LCD stream capture into a 160x144 2-bit frame buffer.
// Define GB_LCD_CAPTURE_PACK_EN to pack 4 pixels per 8-bit write.
module gb_lcd_capture
  import gb_video_pkg::*;
#(
  parameter int H_ACTIVE    = GB_H_ACTIVE,
  parameter int V_ACTIVE    = GB_V_ACTIVE,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture_en,
  input  logic              gb_hs,
  input  logic              gb_vs,
  input  logic              gb_cpl,
  input  logic [1:0]        gb_pixel,
  input  logic              gb_valid,
  output logic              fb_we,
`ifdef GB_LCD_CAPTURE_PACK_EN
  output logic [ADDR_W-3:0] fb_addr,
  output logic [7:0]        fb_wdata,
`else
  output logic [ADDR_W-1:0] fb_addr,
  output logic [1:0]        fb_wdata,
`endif
  output logic              frame_done,
  output logic [7:0]        line_cnt,
  output logic              overrun
);

`ifdef GB_LCD_CAPTURE_PACK_EN
  localparam int OAW = ADDR_W - 2;
  localparam int OW  = 8;
`else
  localparam int OAW = ADDR_W;
  localparam int OW  = 2;
`endif
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0]     X_MAX  = XW'(H_ACTIVE);
  localparam logic [YW-1:0]     Y_MAX  = YW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

  logic [3:0] ctl_s, ctl_r;
  logic [1:0] pix_s, pix_r;

  gb_sig_sync #(.N(SYNC_STAGES), .W(4)) u_ctl_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    ({gb_hs, gb_vs, gb_cpl, gb_valid}),
    .q_o    (ctl_s),
    .rise_o (ctl_r)
  );

  gb_sig_sync #(.N(SYNC_STAGES), .W(2)) u_pix_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (gb_pixel),
    .q_o    (pix_s),
    .rise_o (pix_r)
  );

  logic hs_ev, vs_ev, cpl_ev, valid_s;
  logic unused_sync;
  assign hs_ev       = ctl_r[3];
  assign vs_ev       = ctl_r[2];
  assign cpl_ev      = ctl_r[1];
  assign valid_s     = ctl_s[0];
  assign unused_sync = ^{ctl_s[3:1], ctl_r[0], pix_r};

  cap_state_e        state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [7:0]        line_q, line_d;
  logic              we_q, we_d;
  logic [OAW-1:0]    addr_q, addr_d;
  logic [OW-1:0]     wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
`ifdef GB_LCD_CAPTURE_PACK_EN
  logic [7:0]        acc_q, acc_d, acc_nx;
  logic              pend_q, pend_d;
  logic [OAW-1:0]    wa_q, wa_d;
`endif

  logic [ADDR_W-1:0] idx;
  logic              in_frame;
  assign idx      = base_q + ADDR_W'(x_q);
  assign in_frame = (x_q < X_MAX) && (y_q < Y_MAX);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    base_d  = base_q;
    line_d  = line_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
`ifdef GB_LCD_CAPTURE_PACK_EN
    acc_d   = acc_q;
    pend_d  = pend_q;
    wa_d    = wa_q;
    acc_nx  = acc_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (capture_en) state_d = WAIT_VS;
      end
      WAIT_VS: begin
        if (vs_ev) begin
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = '0;
          base_d  = '0;
          line_d  = '0;
          ovr_d   = 1'b0;
`ifdef GB_LCD_CAPTURE_PACK_EN
          acc_d   = '0;
          pend_d  = 1'b0;
`endif
        end
      end
      ACTIVE: begin
        if (vs_ev || hs_ev) begin
`ifdef GB_LCD_CAPTURE_PACK_EN
          // close out a partial word; unused slots are already zero
          if (pend_q) begin
            we_d    = 1'b1;
            addr_d  = wa_q;
            wdata_d = acc_q;
            acc_d   = '0;
            pend_d  = 1'b0;
          end
`endif
          x_d = '0;
        end
        if (vs_ev) begin
          done_d = 1'b1;
          if (capture_en) begin
            y_d    = '0;
            base_d = '0;
            line_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (hs_ev) begin
          if (x_q != '0) begin
            if (y_q != Y_MAX) begin
              y_d    = y_q + 1'b1;
              base_d = base_q + H_STEP;
            end
            if (line_q != 8'hFF) line_d = line_q + 8'd1;
          end
        end else if (cpl_ev && valid_s) begin
          if (in_frame) begin
            x_d = x_q + 1'b1;
`ifdef GB_LCD_CAPTURE_PACK_EN
            acc_nx[{idx[1:0], 1'b0} +: 2] = pix_s;
            if (idx[1:0] == 2'd3) begin
              we_d    = 1'b1;
              addr_d  = idx[ADDR_W-1:2];
              wdata_d = acc_nx;
              acc_d   = '0;
              pend_d  = 1'b0;
            end else begin
              acc_d  = acc_nx;
              pend_d = 1'b1;
              wa_d   = idx[ADDR_W-1:2];
            end
`else
            we_d    = 1'b1;
            addr_d  = idx;
            wdata_d = pix_s;
`endif
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      base_q  <= '0;
      line_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef GB_LCD_CAPTURE_PACK_EN
      acc_q   <= '0;
      pend_q  <= 1'b0;
      wa_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      base_q  <= base_d;
      line_q  <= line_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
`ifdef GB_LCD_CAPTURE_PACK_EN
      acc_q   <= acc_d;
      pend_q  <= pend_d;
      wa_q    <= wa_d;
`endif
    end
  end

  assign fb_we      = we_q;
  assign fb_addr    = addr_q;
  assign fb_wdata   = wdata_q;
  assign frame_done = done_q;
  assign line_cnt   = line_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Scoreboard bench for gb_lcd_capture: a frame-level model queues the
// expected writes; a negedge monitor pops and compares every fb_we.
module tb_gb_lcd_capture;

  localparam int H  = 160;
  localparam int V  = 144;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        capture_en = 1'b0;
  logic        gb_hs = 1'b0;
  logic        gb_vs = 1'b0;
  logic        gb_cpl = 1'b0;
  logic [1:0]  gb_pixel = 2'd0;
  logic        gb_valid = 1'b0;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [1:0]  fb_wdata;
  logic        frame_done;
  logic [7:0]  line_cnt;
  logic        overrun;

  always #5 clk = ~clk;

  gb_lcd_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .SYNC_STAGES(SS), .ADDR_W(15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .capture_en(capture_en),
    .gb_hs(gb_hs), .gb_vs(gb_vs), .gb_cpl(gb_cpl),
    .gb_pixel(gb_pixel), .gb_valid(gb_valid),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .frame_done(frame_done), .line_cnt(line_cnt), .overrun(overrun)
  );

  typedef struct packed {
    logic [14:0] a;
    logic [1:0]  d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_w;
  int  vectors = 0;
  int  miscompares = 0;
  int  seen_done = 0;
  int  last_addr = -1;

  // frame-level reference model
  bit  m_cap, m_armed, m_en, m_ovr;
  int  m_x, m_y, m_line, m_done;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (fb_we) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr %0d data %0d, none expected",
                 fb_addr, fb_wdata);
      end else begin
        mon_w = exp_q.pop_front();
        check("wr_addr", int'(fb_addr), int'(mon_w.a));
        check("wr_data", int'(fb_wdata), int'(mon_w.d));
      end
      last_addr = int'(fb_addr);
    end
    if (frame_done) seen_done++;
  end

  function automatic void m_reset();
    m_cap = 0; m_armed = m_en; m_ovr = 0;
    m_x = 0; m_y = 0; m_line = 0;
  endfunction

  function automatic void set_cap(input bit v);
    m_en = v;
    capture_en = v;
    if (v && !m_cap) m_armed = 1;
  endfunction

  function automatic void m_vs();
    if (m_cap) begin
      m_done++;
      if (m_en) begin
        m_x = 0; m_y = 0; m_line = 0;
      end else begin
        m_cap = 0; m_armed = 0;
      end
    end else if (m_armed) begin
      m_cap = 1; m_armed = 0; m_ovr = 0;
      m_x = 0; m_y = 0; m_line = 0;
    end
  endfunction

  function automatic void m_hs();
    if (!m_cap) return;
    if (m_x > 0) begin
      if (m_y < V) m_y++;
      if (m_line < 255) m_line++;
    end
    m_x = 0;
  endfunction

  function automatic void m_pix(input logic [1:0] p, input bit v);
    if (!(m_cap && v)) return;
    if (m_x < H && m_y < V) begin
      exp_q.push_back({15'(m_y * H + m_x), p});
      m_x++;
    end else begin
      m_ovr = 1;
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pix(input logic [1:0] p, input bit v);
    m_pix(p, v);
    gb_pixel = p; gb_valid = v;
    tick(1); gb_cpl = 1'b1;
    tick(2); gb_cpl = 1'b0;
    tick(2);
  endtask

  task automatic pix_lat(input logic [1:0] p, output int lat);
    m_pix(p, 1'b1);
    gb_pixel = p; gb_valid = 1'b1;
    tick(1); gb_cpl = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 2) gb_cpl = 1'b0;
      if (fb_we && lat == 0) lat = i;
    end
  endtask

  task automatic hs_pulse();
    m_hs();
    gb_hs = 1'b1; tick(2);
    gb_hs = 1'b0; tick(3);
  endtask

  task automatic vs_pulse(input bit with_cpl);
    m_vs();
    gb_pixel = 2'(($urandom_range(0, 3))); gb_valid = 1'b1;
    tick(1);
    gb_vs = 1'b1; gb_cpl = with_cpl;
    tick(2);
    gb_vs = 1'b0; gb_cpl = 1'b0;
    tick(2);
  endtask

  task automatic checkpoint(input string tag);
    tick(6);
    check({tag, "_drain"}, exp_q.size(), 0);
    check({tag, "_line_cnt"}, int'(line_cnt), m_line);
    check({tag, "_overrun"}, int'(overrun), int'(m_ovr));
    check({tag, "_frame_done"}, seen_done, m_done);
  endtask

  // short lines up to y=142 then a full last line ending at 23039
  task automatic fill_frame(input int drop_at);
    while (m_y < V - 1) begin
      if (m_y == drop_at) set_cap(1'b0);
      for (int i = 0; i < int'($urandom_range(1, 3)); i++)
        pix(2'($urandom_range(0, 3)), 1'b1);
      hs_pulse();
    end
    for (int i = 0; i < H; i++) pix(2'($urandom_range(0, 3)), 1'b1);
    tick(6);
    check("last_addr", last_addr, H * V - 1);
    hs_pulse();
  endtask

  task automatic random_frame();
    int nl, r, n;
    nl = $urandom_range(140, 150);
    for (int l = 0; l < nl; l++) begin
      r = $urandom_range(0, 39);
      n = (r == 0) ? 161 + $urandom_range(0, 2)
        : (r < 3)  ? 0 : $urandom_range(1, 4);
      for (int i = 0; i < n; i++)
        pix(2'($urandom_range(0, 3)), $urandom_range(0, 7) != 0);
      hs_pulse();
    end
    vs_pulse(1'b0);
    checkpoint("rand_frame");
  endtask

  int lat;

  initial begin
    m_en = 0; m_done = 0;
    m_reset();

    for (int i = 0; i < 5; i++) begin
      gb_cpl = ~gb_cpl;
      @(negedge clk);
      check("rst_fb_we", int'(fb_we), 0);
      check("rst_frame_done", int'(frame_done), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_line_cnt", int'(line_cnt), 0);
    end
    gb_cpl = 1'b0;
    rst_n = 1'b1;
    tick(4);

    set_cap(1'b1);
    tick(3);
    vs_pulse(1'b0);
    for (int i = 0; i < H; i++) pix(2'(i % 4), 1'b1);
    hs_pulse();
    checkpoint("line0");

    fill_frame(-1);
    vs_pulse(1'b0);
    checkpoint("full_frame");

    for (int i = 0; i < H + 1; i++) pix(2'($urandom_range(0, 3)), 1'b1);
    checkpoint("overrun_set");
    hs_pulse();
    vs_pulse(1'b0);
    checkpoint("overrun_sticky");

    fill_frame(70);
    vs_pulse(1'b0);
    checkpoint("cap_drop");
    vs_pulse(1'b0);
    for (int i = 0; i < 20; i++) pix(2'($urandom_range(0, 3)), 1'b1);
    hs_pulse();
    checkpoint("idle_no_write");

    set_cap(1'b1);
    tick(3);
    vs_pulse(1'b0);
    checkpoint("rearm");
    for (int i = 0; i < 5; i++) pix(2'($urandom_range(0, 3)), 1'b1);
    vs_pulse(1'b1);
    pix_lat(2'd3, lat);
    check("cpl_latency", lat, SS + 2);
    checkpoint("vs_cpl_align");

    for (int f = 0; f < 3; f++) random_frame();

    for (int i = 0; i < 7; i++) pix(2'($urandom_range(0, 3)), 1'b1);
    tick(6);
    rst_n = 1'b0;
    tick(3);
    m_reset();
    check("midrst_line_cnt", int'(line_cnt), 0);
    check("midrst_fb_we", int'(fb_we), 0);
    rst_n = 1'b1;
    tick(3);
    vs_pulse(1'b0);
    for (int i = 0; i < 4; i++) pix(2'($urandom_range(0, 3)), 1'b1);
    hs_pulse();
    checkpoint("after_reset");

    tick(10);
    check("final_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gb_lcd_capture.md
Name: gb_lcd_capture

Overview:
- Consumes the Game Boy core's raw LCD pixel stream (hs, vs, cpl, pixel, valid) and writes it into a 160x144 2-bit frame buffer through a single write port.
- Sits between the gameboy core and the display mixer, which reads the frame buffer from the other BRAM port.
- Runs in one fast clock domain (the DVI/pixel clock).
- Oversamples the slow LCD signals, detects strobe edges, generates linear addresses, and gates capture to whole frames.

Parameters:
- H_ACTIVE, 160, pixels per line written to the buffer
- V_ACTIVE, 144, lines per frame written to the buffer
- SYNC_STAGES, 2, synchroniser flops on every LCD input (min 2)
- ADDR_W, 15, frame buffer address width (must hold H_ACTIVE*V_ACTIVE-1)

Ports:
- clk  in  1  capture clock, ≥4x the LCD pixel strobe rate
- rst_n  in  1  synchronous reset, active low
- capture_en  in  1  request capture; sampled only at frame boundaries
- gb_hs  in  1  LCD line latch (async to clk)
- gb_vs  in  1  LCD frame sync, active high (async)
- gb_cpl  in  1  LCD pixel strobe (async)
- gb_pixel  in  2  pixel shade (async, stable ≥SYNC_STAGES+1 clk around cpl rise)
- gb_valid  in  1  pixel valid qualifier (async)
- fb_we  out  1  frame buffer write strobe, one clk per pixel
- fb_addr  out  ADDR_W  write address = y*H_ACTIVE + x
- fb_wdata  out  2  pixel data
- frame_done  out  1  one-clk pulse when a captured frame closes
- line_cnt  out  8  lines seen in current frame (saturates at 255)
- overrun  out  1  sticky: pixel arrived with x≥H_ACTIVE or y≥V_ACTIVE

Behaviour:
- Reset: on clk rise with rst_n=0, all outputs 0; x=0; y=0; state=IDLE; synchroniser flops cleared.
- Reset mid-frame drops the partial frame. No write issues in the reset cycle.
- Inputs pass through SYNC_STAGES flops, then one edge-detect flop.
- Rising edges of synchronised hs, vs and cpl each yield a one-clk event.
- State machine:
  - IDLE: if capture_en=1 → WAIT_VS.
  - WAIT_VS: on vs event → ACTIVE, with x=0, y=0, line_cnt=0.
  - ACTIVE: on vs event, pulse frame_done. Then if capture_en=1, restart the frame (x=y=line_cnt=0, stay ACTIVE); else → IDLE.
- capture_en deasserting mid-frame takes effect only at the next vs. The current frame completes.
- Pixel event (ACTIVE, cpl event, synced valid=1):
  - If x<H_ACTIVE and y<V_ACTIVE: fb_we=1 next clk, fb_addr=y*H_ACTIVE+x, fb_wdata=synced pixel, then x++.
  - Otherwise: no write, overrun←1.
- Pixel latency: 1 clk from cpl event to fb_we, i.e. SYNC_STAGES+2 clk from raw cpl rise.
- Address: an incrementing running base, not a multiplier. base += H_ACTIVE on each line advance; fb_addr = base + x.
- hs event (ACTIVE):
  - If x>0: y++ (saturate at V_ACTIVE), line_cnt++ (saturate at 255).
  - Always: x=0.
  - An hs event with x=0 (blank line latch) does not advance y.
- Simultaneous events in one clk, priority vs > hs > cpl.
  - vs+cpl: the pixel is dropped and counted as the first event of the new frame only if still present next edge. It is never written.
  - hs+cpl: line advance first, pixel not written.
- overrun clears only on reset or on the WAIT_VS→ACTIVE transition.
- No backpressure: the write port is a free BRAM port and fb_we is never stalled.

Optional Feature:
- Macro: GB_LCD_CAPTURE_PACK_EN.
- Defined:
  - Pixels accumulate 4-at-a-time into an 8-bit word. fb_wdata widens to 8, fb_addr to ADDR_W-2, and address = pixel index>>2.
  - Pixel 0 goes in bits [1:0].
  - fb_we pulses once per 4 pixels.
  - A partial word at an hs or vs event is flushed with unused slots zero.
- Not defined: one 2-bit write per pixel as above.

Decomposition:
- Package gb_video_pkg: GB_H_ACTIVE=160, GB_V_ACTIVE=144, FB_ADDR_W=15, and the capture state enum (IDLE, WAIT_VS, ACTIVE).
- Sub-module gb_sig_sync: parameterised N-stage synchroniser plus rising-edge detector. Instantiated for hs, vs, cpl and valid. pixel uses the synchroniser only.

Test Plan:
- Reset held 5 clk while cpl toggles → fb_we, frame_done, overrun, line_cnt all 0. x and y stay 0 after release.
- capture_en=1, vs pulse, then 160 cpl strobes with pixel=x%4, valid=1, then hs → 160 writes at addr 0..159 with wdata=addr%4; line_cnt=1.
- Full frame of 144 lines x 160 pixels then vs → last write addr 23039, frame_done pulse exactly 1 clk, overrun=0.
- 161st cpl strobe on line 0 → no write, overrun=1 and sticky until the next WAIT_VS→ACTIVE transition.
- capture_en dropped at line 70 → frame finishes to addr 23039, then IDLE. Next vs produces no writes.
- vs and cpl edges aligned in the same clk → no write for that strobe; x=0, y=0 afterward.
